nes_joypad: RTL and testbench



---
 rtl/nes_joypad.sv | 101 ++++++++++
 tb/tb_nes_joypad.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/nes_joypad.sv
// Controller port pair at $4016/$4017: strobe latch, two 8-bit serial shift
// registers, and frame-locked turbo for A/B.
module nes_joypad #(
    parameter int TURBO_FRAMES = 2
) (
    input  logic        i_cpu_clk,
    input  logic        i_rstn_nes,
    input  logic        i_bus_en,
    input  logic [15:0] i_bus_addr,
    input  logic        i_bus_wn,
    input  logic [7:0]  i_bus_wdata,
    input  logic        i_vblank,
    input  logic [9:0]  i_jp_vec_1p,
    input  logic [9:0]  i_jp_vec_2p,
    output logic        o_jp_hit,
    output logic [7:0]  o_jp_rdata
);

    localparam logic [3:0] TURBO_LAST = 4'(TURBO_FRAMES - 1);

    logic [9:0] r_btn_1p, r_btn_2p;
    logic       r_vb_d;
    logic [3:0] r_turbo_cnt;
    logic       r_turbo_phase;
    logic       r_strobe;
    logic [7:0] r_sh_1p, r_sh_2p;

    // Serial order seen by the game, LSB first.
    function automatic logic [7:0] snapshot(input logic [9:0] btn, input logic phase);
        logic eff_a, eff_b;
        eff_a = btn[5] | (btn[3] & phase);
        eff_b = btn[4] | (btn[2] & phase);
        return {btn[6], btn[7], btn[8], btn[9], btn[0], btn[1], eff_b, eff_a};
    endfunction

    logic       sel_4016, sel_4017;
    logic       rd_1p, rd_2p, wr_strobe, vb_edge;
    logic [7:0] snap_1p, snap_2p;
    logic       bit_1p, bit_2p;
    logic       unused_wdata;

    assign sel_4016  = (i_bus_addr == 16'h4016);
    assign sel_4017  = (i_bus_addr == 16'h4017);
    assign rd_1p     = i_bus_en & i_bus_wn & sel_4016;
    assign rd_2p     = i_bus_en & i_bus_wn & sel_4017;
    assign wr_strobe = i_bus_en & ~i_bus_wn & sel_4016;
    assign vb_edge   = i_vblank & ~r_vb_d;

    assign snap_1p = snapshot(r_btn_1p, r_turbo_phase);
    assign snap_2p = snapshot(r_btn_2p, r_turbo_phase);

    // While strobing, the port is transparent to the live A button.
    assign bit_1p = r_strobe ? snap_1p[0] : r_sh_1p[0];
    assign bit_2p = r_strobe ? snap_2p[0] : r_sh_2p[0];

    assign o_jp_hit   = rd_1p | rd_2p;
    assign o_jp_rdata = o_jp_hit ? {7'b0100_000, (rd_2p ? bit_2p : bit_1p)} : 8'h00;

    // Only bit 0 of the strobe write is meaningful.
    assign unused_wdata = ^i_bus_wdata[7:1];

    always_ff @(posedge i_cpu_clk) begin
        if (!i_rstn_nes) begin
            r_btn_1p      <= '0;
            r_btn_2p      <= '0;
            r_vb_d        <= 1'b0;
            r_turbo_cnt   <= '0;
            r_turbo_phase <= 1'b0;
            r_strobe      <= 1'b0;
            r_sh_1p       <= 8'hFF;
            r_sh_2p       <= 8'hFF;
        end else begin
            r_btn_1p <= i_jp_vec_1p;
            r_btn_2p <= i_jp_vec_2p;
            r_vb_d   <= i_vblank;

            if (vb_edge) begin
                if (r_turbo_cnt == TURBO_LAST) begin
                    r_turbo_cnt   <= '0;
                    r_turbo_phase <= ~r_turbo_phase;
                end else begin
                    r_turbo_cnt <= r_turbo_cnt + 4'd1;
                end
            end

            if (wr_strobe) begin
                r_strobe <= i_bus_wdata[0];
            end

            // Reload uses the current strobe, so a write of 0 still gets one last load.
            if (r_strobe) begin
                r_sh_1p <= snap_1p;
                r_sh_2p <= snap_2p;
            end else begin
                if (rd_1p) r_sh_1p <= {1'b1, r_sh_1p[7:1]};
                if (rd_2p) r_sh_2p <= {1'b1, r_sh_2p[7:1]};
            end
        end
    end

endmodule

// File: tb/tb_nes_joypad.sv
// Scoreboard bench for nes_joypad: reads push expected bytes, samples pop them.
module tb_nes_joypad;

    logic        clk = 1'b0;
    logic        rstn;
    logic        bus_en;
    logic [15:0] bus_addr;
    logic        bus_wn;
    logic [7:0]  bus_wdata;
    logic        vblank;
    logic [9:0]  vec1, vec2;
    logic        jp_hit;
    logic [7:0]  jp_rdata;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    nes_joypad #(.TURBO_FRAMES(2)) dut (
        .i_cpu_clk   (clk),
        .i_rstn_nes  (rstn),
        .i_bus_en    (bus_en),
        .i_bus_addr  (bus_addr),
        .i_bus_wn    (bus_wn),
        .i_bus_wdata (bus_wdata),
        .i_vblank    (vblank),
        .i_jp_vec_1p (vec1),
        .i_jp_vec_2p (vec2),
        .o_jp_hit    (jp_hit),
        .o_jp_rdata  (jp_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus_en = 1'b1; bus_addr = a; bus_wn = 1'b0; bus_wdata = d;
        @(posedge clk); #1;
        bus_en = 1'b0; bus_wn = 1'b1;
    endtask

    task automatic latch();
        wr(16'h4016, 8'h01);
        wr(16'h4016, 8'h00);
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] exp, input logic exp_hit);
        logic [7:0] e;
        exp_q.push_back(exp);
        bus_en = 1'b1; bus_addr = a; bus_wn = 1'b1;
        @(negedge clk);
        e = exp_q.pop_front();
        chk({tag, "_hit"}, 32'(jp_hit), 32'(exp_hit));
        if (exp_hit) chk(tag, 32'(jp_rdata), 32'(e));
        @(posedge clk); #1;
        bus_en = 1'b0;
    endtask

    function automatic logic [7:0] ref_snap(input logic [9:0] b, input logic ph);
        logic [7:0] s;
        s[0] = b[5] | (b[3] & ph);
        s[1] = b[4] | (b[2] & ph);
        s[2] = b[1];
        s[3] = b[0];
        s[4] = b[9];
        s[5] = b[8];
        s[6] = b[7];
        s[7] = b[6];
        return s;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [7:0] pat;
        logic [7:0] s;
        logic [9:0] v;

        rstn = 1'b0; bus_en = 1'b0; bus_addr = 16'h0; bus_wn = 1'b1; bus_wdata = 8'h0;
        vblank = 1'b0; vec1 = '0; vec2 = '0;
        idle(3);
        rstn = 1'b1;
        idle(1);

        // Reset state
        @(negedge clk);
        chk("rst_hit", 32'(jp_hit), 32'd0);
        chk("rst_strobe", 32'(dut.r_strobe), 32'd0);
        chk("rst_sh1", 32'(dut.r_sh_1p), 32'hFF);
        @(posedge clk); #1;

        for (int i = 0; i < 3; i++) rd("idle_rd", 16'h4016, 8'h41, 1'b1);
        chk("idle_sh1", 32'(dut.r_sh_1p), 32'hFF);

        // Undecoded address and $4017 write leave state alone
        rd("nohit", 16'h4015, 8'h00, 1'b0);
        wr(16'h4017, 8'h01);
        chk("w4017_strobe", 32'(dut.r_strobe), 32'd0);

        // Right + Start serial sequence, then trailing ones
        vec1 = 10'b0001_0000_01;
        idle(2);
        latch();
        pat = 8'b1000_1000;
        for (int i = 0; i < 8; i++) rd("rs_bit", 16'h4016, 8'h40 | 8'(pat[i]), 1'b1);
        rd("rs_tail", 16'h4016, 8'h41, 1'b1);
        rd("rs_tail", 16'h4016, 8'h41, 1'b1);

        // Strobe held: live A with one register stage, no shifting
        wr(16'h4016, 8'h01);
        vec1 = 10'h020;
        rd("stb_a0", 16'h4016, 8'h40, 1'b1);
        rd("stb_a1", 16'h4016, 8'h41, 1'b1);
        vec1 = 10'h000;
        rd("stb_a2", 16'h4016, 8'h41, 1'b1);
        rd("stb_a3", 16'h4016, 8'h40, 1'b1);
        vec1 = 10'h020;
        idle(2);
        wr(16'h4016, 8'h00);
        rd("stb_lat_a", 16'h4016, 8'h41, 1'b1);
        rd("stb_lat_b", 16'h4016, 8'h40, 1'b1);

        // Turbo A, half-period 2 frames
        vec1 = 10'h008;
        idle(2);
        pat = 8'h66;
        for (int p = 0; p < 8; p++) begin
            vblank = 1'b1;
            idle(2);
            vblank = 1'b0;
            idle(1);
            latch();
            rd("turbo", 16'h4016, 8'h40 | 8'(pat[p]), 1'b1);
        end

        // Random pads against the reference snapshot (turbo phase is back to 0)
        for (int k = 0; k < 4; k++) begin
            v = 10'($urandom_range(0, 1023));
            vec1 = v;
            idle(2);
            latch();
            s = ref_snap(v, 1'b0);
            for (int i = 0; i < 8; i++) rd("rand_bit", 16'h4016, 8'h40 | 8'(s[i]), 1'b1);
            rd("rand_tail", 16'h4016, 8'h41, 1'b1);
        end

        // Independent pad shift registers
        vec1 = 10'h000;
        vec2 = 10'h010;
        idle(2);
        latch();
        rd("p2_a", 16'h4017, 8'h40, 1'b1);
        rd("p1_a", 16'h4016, 8'h40, 1'b1);
        rd("p2_b", 16'h4017, 8'h41, 1'b1);
        rd("p1_b", 16'h4016, 8'h40, 1'b1);
        rd("p2_sel", 16'h4017, 8'h40, 1'b1);

        // Reset mid-sequence overrides a same-cycle strobe write and vblank edge
        vec1 = 10'h020;
        vec2 = 10'h000;
        idle(2);
        latch();
        rd("pre_rst_a", 16'h4016, 8'h41, 1'b1);
        rd("pre_rst_b", 16'h4016, 8'h40, 1'b1);
        rd("pre_rst_s", 16'h4016, 8'h40, 1'b1);
        rstn = 1'b0;
        bus_en = 1'b1; bus_addr = 16'h4016; bus_wn = 1'b0; bus_wdata = 8'h01;
        vblank = 1'b1;
        @(posedge clk); #1;
        rstn = 1'b1; bus_en = 1'b0; bus_wn = 1'b1; vblank = 1'b0;
        chk("mid_rst_strobe", 32'(dut.r_strobe), 32'd0);
        chk("mid_rst_cnt", 32'(dut.r_turbo_cnt), 32'd0);
        rd("post_rst", 16'h4016, 8'h41, 1'b1);
        chk("post_rst_sh1", 32'(dut.r_sh_1p), 32'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
